hyperbus_rx_packer: RTL and testbench

//  Downstream of the RX CDC FIFO on the AXI clock side. Packs the 16-bit HyperBus read stream
//  (data/last/error) into AXI_DW-bit R beats for the AXI slave front-end, honouring the start lane
//  and beat count of the read command. Grades responses per beat and handles stream/command

---
 rtl/hyperbus_rx_packer_pkg.sv | 25 ++
 rtl/hyperbus_rx_packer.sv | 164 ++++++++++++++++
 tb/tb_hyperbus_rx_packer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_rx_packer_pkg.sv
// Shared types for the HyperBus RX packer and the AXI front-end:
// packer FSM states, RX word and command structs, AXI response codes.
package hyperbus_rx_packer_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic        last;
    logic        error;
    logic [15:0] data;
  } rx_word_t;

  typedef struct packed {
    logic [7:0] len;
  } cmd_t;

endpackage

// File: rtl/hyperbus_rx_packer.sv
// Packs the 16-bit HyperBus read stream into AXI R beats, with short/long stream recovery.
// Optional macro HYPERBUS_RX_PACKER_BYTE_SWAP_EN byte-swaps every word before packing.
module hyperbus_rx_packer
  import hyperbus_rx_packer_pkg::*;
#(
  parameter int AXI_DW = 64,
  parameter int AXI_IW = 10,
  localparam int WPB = AXI_DW / 16,
  localparam int LW  = $clog2(WPB)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LW-1:0]     cmd_offset_i,
  input  logic [7:0]        cmd_len_i,
  input  logic [AXI_IW-1:0] cmd_id_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [15:0]       rx_data_i,
  input  logic              rx_last_i,
  input  logic              rx_error_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [AXI_DW-1:0] r_data_o,
  output logic [1:0]        r_resp_o,
  output logic              r_last_o,
  output logic [AXI_IW-1:0] r_id_o,
  output state_t            dbg_state_o
);

  localparam logic [LW-1:0] LAST_LANE = LW'(WPB - 1);

  state_t              state_q, state_d;
  cmd_t                cmd_q;
  logic [AXI_IW-1:0]   id_q;
  logic [LW-1:0]       lane;
  logic [8:0]          beat;
  logic                err;
  logic                last_seen;
  logic [AXI_DW-1:0]   pack_data;
  logic [AXI_DW-1:0]   merged;
  rx_word_t            rx_w;

  logic out_free, completing, is_final, beat_left;
  logic pack_acc, load_beat, load_zero;

`ifdef HYPERBUS_RX_PACKER_BYTE_SWAP_EN
  assign rx_w = '{last: rx_last_i, error: rx_error_i, data: {rx_data_i[7:0], rx_data_i[15:8]}};
`else
  assign rx_w = '{last: rx_last_i, error: rx_error_i, data: rx_data_i};
`endif

  assign out_free   = !r_valid_o || r_ready_i;
  assign completing = (lane == LAST_LANE) || rx_w.last;
  assign is_final   = (beat == {1'b0, cmd_q.len});
  assign beat_left  = (beat <= {1'b0, cmd_q.len});
  assign r_id_o      = id_q;
  assign dbg_state_o = state_q;

  always_comb begin
    merged = pack_data;
    merged[{lane, 4'b0000} +: 16] = rx_w.data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    rx_ready_o  = 1'b0;
    pack_acc    = 1'b0;
    load_beat   = 1'b0;
    load_zero   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = !r_valid_o;
        if (cmd_valid_i && !r_valid_o) state_d = ST_PACK;
      end
      ST_PACK: begin
        // Only the word that completes a beat can stall, and only when the output reg is busy.
        rx_ready_o = !completing || out_free;
        if (rx_valid_i && rx_ready_o) begin
          pack_acc = 1'b1;
          if (completing) begin
            load_beat = 1'b1;
            if (is_final)       state_d = rx_w.last ? ST_IDLE : ST_DRAIN;
            else if (rx_w.last) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        load_zero = out_free && beat_left;
        if (r_valid_o && r_last_o && r_ready_i) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        rx_ready_o = 1'b1;
        if ((last_seen || (rx_valid_i && rx_w.last)) && out_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q     <= '0;
      id_q      <= '0;
      lane      <= '0;
      beat      <= '0;
      err       <= 1'b0;
      last_seen <= 1'b0;
      pack_data <= '0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_resp_o  <= RESP_OKAY;
      r_last_o  <= 1'b0;
    end else begin
      if (r_valid_o && r_ready_i) r_valid_o <= 1'b0;

      if (cmd_ready_o && cmd_valid_i) begin
        cmd_q.len <= cmd_len_i;
        id_q      <= cmd_id_i;
        lane      <= cmd_offset_i;
        beat      <= '0;
        err       <= 1'b0;
        last_seen <= 1'b0;
        pack_data <= '0;
      end

      if (pack_acc) begin
        if (load_beat) begin
          r_valid_o <= 1'b1;
          r_data_o  <= merged;
          // A final beat completed without rx_last means the stream overran the command.
          r_resp_o  <= (err || rx_w.error || (is_final && !rx_w.last)) ? RESP_SLVERR : RESP_OKAY;
          r_last_o  <= is_final;
          lane      <= '0;
          beat      <= beat + 9'd1;
          err       <= 1'b0;
          pack_data <= '0;
        end else begin
          pack_data <= merged;
          lane      <= lane + LW'(1);
          err       <= err | rx_w.error;
        end
      end

      if (load_zero) begin
        r_valid_o <= 1'b1;
        r_data_o  <= '0;
        r_resp_o  <= RESP_SLVERR;
        r_last_o  <= is_final;
        beat      <= beat + 9'd1;
      end

      if (state_q == ST_DRAIN && rx_valid_i && rx_w.last) last_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hyperbus_rx_packer.sv
// Randomized self-checking bench for hyperbus_rx_packer (AXI_DW=64) against a beat-level model.
module tb_hyperbus_rx_packer;
  import hyperbus_rx_packer_pkg::*;

  localparam int AXI_DW = 64;
  localparam int AXI_IW = 10;
  localparam int WPB    = AXI_DW / 16;
  localparam int LW     = $clog2(WPB);
  localparam int W      = AXI_DW + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LW-1:0]     cmd_offset = '0;
  logic [7:0]        cmd_len = '0;
  logic [AXI_IW-1:0] cmd_id = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [15:0]       rx_data = '0;
  logic              rx_last = 1'b0;
  logic              rx_error = 1'b0;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [AXI_DW-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [AXI_IW-1:0] r_id;
  state_t            dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  hyperbus_rx_packer #(.AXI_DW(AXI_DW), .AXI_IW(AXI_IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_offset_i(cmd_offset),
    .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
    .rx_last_i(rx_last), .rx_error_i(rx_error),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_resp_o(r_resp),
    .r_last_o(r_last), .r_id_o(r_id), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {last, resp, data} per expected beat
  logic [W-1:0]      exp_q[$];
  logic [15:0]       wd[$];
  bit                we[$];
  bit                ws[$];
  logic [AXI_IW-1:0] cur_id;

  function automatic logic [15:0] lane_word(input logic [15:0] d);
`ifdef HYPERBUS_RX_PACKER_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  // Beat-level model: walk the word list lane by lane; missing words give zero SLVERR beats,
  // an unterminated final beat is SLVERR. ws marks words that complete a beat while packing.
  task automatic build_model(input int off, input int len);
    int i = 0;
    bit ended = 0;
    exp_q.delete();
    ws.delete();
    for (int k = 0; k < wd.size(); k++) ws.push_back(1'b0);
    for (int b = 0; b <= len; b++) begin
      logic [AXI_DW-1:0] data = '0;
      bit e = ended;
      if (!ended) begin
        int lane = (b == 0) ? off : 0;
        while (lane < WPB && !ended) begin
          data[lane*16 +: 16] = lane_word(wd[i]);
          e = e | we[i];
          if (lane == WPB - 1 || i == wd.size() - 1) ws[i] = 1'b1;
          if (i == wd.size() - 1) ended = 1;
          i++;
          lane++;
        end
        if (b == len && !ended) e = 1;
      end
      exp_q.push_back({(b == len), (e ? 2'b10 : 2'b00), data});
    end
  endtask

  task automatic issue_cmd(input int off, input int len, input logic [AXI_IW-1:0] id);
    int t = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_offset = LW'(off);
    cmd_len    = 8'(len);
    cmd_id     = id;
    #1;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    cur_id = id;
    build_model(off, len);
  endtask

  // Driver + monitor in one process so word and beat handshakes are judged on the same cycle.
  task automatic run_stream(input int valid_pct, input int ready_pct, input int hold,
                            input int rst_cyc, output int stalls);
    int ptr = 0;
    int cyc = 0;
    int n = wd.size();
    bit lat_pend = 0;
    stalls = 0;
    while ((ptr < n || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (lat_pend) begin
        checks++;
        if (r_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: r_valid=%0b required 1", r_valid);
        end
        lat_pend = 0;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        rx_valid = 1'b0;
        r_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rx_ready, r_valid, r_data, r_resp, r_last, r_id} !==
            {1'b1, 1'b0, 1'b0, {AXI_DW{1'b0}}, 2'b00, 1'b0, {AXI_IW{1'b0}}}) begin
          errors++;
          $display("FAIL reset_mid: cr=%0b rr=%0b rv=%0b d=%h resp=%0d last=%0b id=%0d required 1 0 0 0 0 0 0",
                   cmd_ready, rx_ready, r_valid, r_data, r_resp, r_last, r_id);
        end
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      rx_valid = (ptr < n) && ($urandom_range(0, 99) < valid_pct);
      rx_data  = (ptr < n) ? wd[ptr] : 16'h0;
      rx_error = (ptr < n) ? we[ptr] : 1'b0;
      rx_last  = (ptr == n - 1);
      r_ready  = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      #1;
      if (rx_valid && !ws[ptr]) begin
        checks++;
        if (rx_ready !== 1'b1) begin
          errors++;
          $display("FAIL no_stall: word %0d rx_ready=%0b required 1", ptr, rx_ready);
        end
      end
      if (rx_valid && !rx_ready && ptr == 7) stalls++;
      if (r_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: data=%h with no beat expected", r_data);
        end else begin
          if ({r_last, r_resp, r_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL beat: got last=%0b resp=%0d data=%h required last=%0b resp=%0d data=%h",
                     r_last, r_resp, r_data, exp_q[0][W-1], exp_q[0][W-2:W-3], exp_q[0][AXI_DW-1:0]);
          end
          checks++;
          if (r_id !== cur_id) begin
            errors++;
            $display("FAIL r_id: got %0d required %0d", r_id, cur_id);
          end
          if (r_ready) void'(exp_q.pop_front());
        end
      end
      if (rx_valid && rx_ready) begin
        if (ws[ptr]) lat_pend = 1;
        ptr++;
      end
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    r_ready  = 1'b0;
    checks++;
    if (ptr != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_done: words %0d/%0d beats left %0d required all done", ptr, n, exp_q.size());
    end
  endtask

  task automatic set_words(input int n, input int first);
    wd.delete();
    we.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back(16'(first + i));
      we.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0b required 1", cmd_ready); end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %0b required 0", rx_ready); end
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL rst_r_valid: got %0b required 0", r_valid); end
    checks++;
    if (r_data !== '0) begin errors++; $display("FAIL rst_r_data: got %h required 0", r_data); end
    checks++;
    if ({r_resp, r_last} !== 3'b000) begin errors++; $display("FAIL rst_resp_last: got %0d %0b required 0 0", r_resp, r_last); end
    checks++;
    if (r_id !== '0) begin errors++; $display("FAIL rst_r_id: got %0d required 0", r_id); end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
    rst = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0) begin errors++; $display("FAIL idle_rx_ready: got %0b required 0", rx_ready); end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_basic();
    int s;
    set_words(8, 1);
    issue_cmd(0, 1, AXI_IW'($urandom));
    run_stream(100, 100, 0, -1, s);
  endtask

  task automatic test_offset();
    int s;
    wd = '{16'hAAAA, 16'hBBBB};
    we = '{1'b0, 1'b0};
    issue_cmd(2, 0, AXI_IW'($urandom));
    run_stream(100, 100, 0, -1, s);
  endtask

  task automatic test_stall();
    int s;
    set_words(8, 1);
    issue_cmd(0, 1, AXI_IW'($urandom));
    run_stream(100, 100, 10, -1, s);
    checks++;
    if (s != 3) begin errors++; $display("FAIL stall_word8: stall cycles %0d required 3", s); end
  endtask

  task automatic test_short();
    int s;
    set_words(5, 1);
    we[1] = 1'b1;
    issue_cmd(0, 3, AXI_IW'($urandom));
    run_stream(100, 100, 0, -1, s);
  endtask

  task automatic test_long();
    int s;
    set_words(6, 16'h10);
    issue_cmd(0, 0, AXI_IW'($urandom));
    run_stream(100, 100, 0, -1, s);
  endtask

  task automatic test_reset_mid();
    int s;
    set_words(8, 1);
    issue_cmd(0, 1, AXI_IW'($urandom));
    run_stream(100, 100, 0, 2, s);
    test_basic();
  endtask

  task automatic test_random();
    int s;
    for (int t = 0; t < 40; t++) begin
      int off  = $urandom_range(0, WPB - 1);
      int len  = $urandom_range(0, 9);
      int need = (WPB - off) + len * WPB;
      int n    = $urandom_range(1, need + 3);
      wd.delete();
      we.delete();
      for (int i = 0; i < n; i++) begin
        wd.push_back(16'($urandom));
        we.push_back($urandom_range(0, 19) == 0);
      end
      issue_cmd(off, len, AXI_IW'($urandom));
      run_stream($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 4), -1, s);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    for (int t = 0; t < 4; t++) begin
      set_words(WPB * 3, t * 64);
      issue_cmd(0, 2, AXI_IW'(t));
      run_stream(100, 100, 0, -1, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_stall();
    test_short();
    test_long();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
